// File: rtl/route_pkg.sv
// Shared definitions for the route matrix slice.
//   ROUTE_CH      : packed-channel slice macro, channel idx of width w in vec
//   ROUTE_W_CHAN  : default data channel width
//   ROUTE_W_SEL   : default select width
//   route_clog2   : ceil(log2(v)), used for blank counter sizing
`ifndef ROUTE_PKG_SV
`define ROUTE_PKG_SV

`define ROUTE_CH(vec, idx, w) vec[(idx)*(w) +: (w)]

package route_pkg;

  localparam int unsigned ROUTE_W_CHAN = 16;
  localparam int unsigned ROUTE_W_SEL  = 4;

  function automatic int unsigned route_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/route_out_slot.sv
// One output channel of the route matrix.
//   clk, rst      : clock, synchronous active-high reset
//   src_data      : all packed input channels
//   src_valid     : per-input valid
//   sel           : active route (source index) for this output
//   route_change  : pulse, the route changes at this clock edge
//   active        : output enable level
//   slot_data     : registered output sample
//   slot_valid    : registered output valid
module route_out_slot
  import route_pkg::*;
#(
  parameter int unsigned W_CHAN    = ROUTE_W_CHAN,
  parameter int unsigned W_SEL     = ROUTE_W_SEL,
  parameter int unsigned N_IN      = 8,
  parameter int unsigned BLANK_CYC = 4,
  parameter bit          IDLE_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W_CHAN*N_IN-1:0]   src_data,
  input  logic [N_IN-1:0]          src_valid,
  input  logic [W_SEL-1:0]         sel,
  input  logic                     route_change,
  input  logic                     active,
  output logic [W_CHAN-1:0]        slot_data,
  output logic                     slot_valid
);

  logic [W_CHAN-1:0] mux_data;
  logic              mux_valid;
  logic              blanking;

  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == i[W_SEL-1:0]) begin
        mux_data  = `ROUTE_CH(src_data, i, W_CHAN);
        mux_valid = src_valid[i];
      end
    end
  end

  // The counter loads on the same edge the route switches, so the sample
  // taken at that edge still comes from the old source and is then held.
  if (BLANK_CYC > 0) begin : g_blank
    localparam int unsigned   CW   = route_clog2(BLANK_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(BLANK_CYC);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst)                cnt <= '0;
      else if (route_change)  cnt <= LOAD;
      else if (cnt != '0)     cnt <= cnt - CW'(1);
    end

    assign blanking = (cnt != '0);
  end else begin : g_no_blank
    logic unused_change;
    assign unused_change = route_change;
    assign blanking      = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_data  <= '0;
      slot_valid <= 1'b0;
    end else if (blanking) begin
      slot_valid <= 1'b0;
    end else if (!active) begin
      slot_valid <= 1'b0;
      if (IDLE_ZERO) slot_data <= '0;
    end else begin
      slot_data  <= mux_data;
      slot_valid <= mux_valid;
    end
  end

endmodule

// File: rtl/route_matrix.sv
// Routes any of N_IN packed input channels to any of N_OUT outputs.
//   clk_in, rst_in    : clock, synchronous active-high reset
//   data_packed_in    : input channels, channel i at [i*W_CHAN +: W_CHAN]
//   data_valid_in     : per-input valid
//   src_select_in     : source index for a route write
//   dest_select_in    : destination index for a route write
//   output_active_in  : per-output enable level
//   update_in         : route write request (rising edge)
//   commit_in         : commit staged table (rising edge, COMMIT_MODE=1)
//   data_packed_out   : registered routed outputs, same packing as input
//   data_valid_out    : per-output valid
//   pending_out       : staged table differs from active table
//   route_err_out     : sticky, an out-of-range write was dropped
module route_matrix
  import route_pkg::*;
#(
  parameter int unsigned W_CHAN      = ROUTE_W_CHAN,
  parameter int unsigned W_SEL       = ROUTE_W_SEL,
  parameter int unsigned N_IN        = 8,
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned COMMIT_MODE = 0,
  parameter int unsigned BLANK_CYC   = 4,
  parameter bit          IDLE_ZERO   = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [W_CHAN*N_IN-1:0]    data_packed_in,
  input  logic [N_IN-1:0]           data_valid_in,
  input  logic [W_SEL-1:0]          src_select_in,
  input  logic [W_SEL-1:0]          dest_select_in,
  input  logic [N_OUT-1:0]          output_active_in,
  input  logic                      update_in,
  input  logic                      commit_in,
  output logic [W_CHAN*N_OUT-1:0]   data_packed_out,
  output logic [N_OUT-1:0]          data_valid_out,
  output logic                      pending_out,
  output logic                      route_err_out
);

  localparam logic [W_SEL:0] N_IN_LIM  = (W_SEL+1)'(N_IN);
  localparam logic [W_SEL:0] N_OUT_LIM = (W_SEL+1)'(N_OUT);

  logic             update_q;
  logic             commit_q;
  logic             upd_edge;
  logic             commit_edge;
  logic             wr_ok;
  logic             wr_bad;
  logic             pending_next;
  logic [W_SEL-1:0] staged      [N_OUT];
  logic [W_SEL-1:0] active      [N_OUT];
  logic [W_SEL-1:0] staged_next [N_OUT];
  logic [W_SEL-1:0] active_next [N_OUT];
  logic [N_OUT-1:0] route_change;

  always_comb begin
    upd_edge     = update_in & ~update_q;
    commit_edge  = commit_in & ~commit_q;
    wr_ok        = upd_edge && ({1'b0, dest_select_in} < N_OUT_LIM)
                            && ({1'b0, src_select_in}  < N_IN_LIM);
    wr_bad       = upd_edge && !wr_ok;
    pending_next = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      staged_next[k] = staged[k];
      if (wr_ok && dest_select_in == k[W_SEL-1:0]) staged_next[k] = src_select_in;
      // Commit takes the post-write table so a same-cycle write is included.
      active_next[k]  = (COMMIT_MODE == 0 || commit_edge) ? staged_next[k] : active[k];
      route_change[k] = (active_next[k] != active[k]);
      if (staged_next[k] != active_next[k]) pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      update_q      <= 1'b0;
      commit_q      <= 1'b0;
      pending_out   <= 1'b0;
      route_err_out <= 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        staged[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      update_q    <= update_in;
      commit_q    <= commit_in;
      pending_out <= pending_next;
      if (wr_bad) route_err_out <= 1'b1;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        staged[k] <= staged_next[k];
        active[k] <= active_next[k];
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    logic [W_CHAN-1:0] lane_data;

    route_out_slot #(
      .W_CHAN    (W_CHAN),
      .W_SEL     (W_SEL),
      .N_IN      (N_IN),
      .BLANK_CYC (BLANK_CYC),
      .IDLE_ZERO (IDLE_ZERO)
    ) u_slot (
      .clk          (clk_in),
      .rst          (rst_in),
      .src_data     (data_packed_in),
      .src_valid    (data_valid_in),
      .sel          (active[k]),
      .route_change (route_change[k]),
      .active       (output_active_in[k]),
      .slot_data    (lane_data),
      .slot_valid   (data_valid_out[k])
    );

    assign `ROUTE_CH(data_packed_out, k, W_CHAN) = lane_data;
  end

endmodule
